// File: rtl/ibex_pmp_csr.sv
`default_nettype none
// ------------------------------------------------------------------------
// ibex_pmp_csr: pmpcfg0-3 / pmpaddr0-15 CSR bank with lock and WARL rules.
// Revision: 1.0
// ------------------------------------------------------------------------

package ibex_pkg;
  typedef enum logic [1:0] {
    PMP_MODE_OFF   = 2'b00,
    PMP_MODE_TOR   = 2'b01,
    PMP_MODE_NA4   = 2'b10,
    PMP_MODE_NAPOT = 2'b11
  } pmp_cfg_mode_e;

  typedef struct packed {
    logic          lock;
    pmp_cfg_mode_e mode;
    logic          exec;
    logic          write;
    logic          read;
  } pmp_cfg_t;
endpackage

module ibex_pmp_csr #(
  parameter int PMPGranularity = 0,
  parameter int PMPNumRegions  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              csr_access_i,
  input  logic [11:0]       csr_addr_i,
  input  logic [1:0]        csr_op_i,
  input  logic [31:0]       csr_wdata_i,
  output logic [31:0]       csr_rdata_o,
  output logic              csr_hit_o,
  output ibex_pkg::pmp_cfg_t csr_pmp_cfg_o [PMPNumRegions],
  output logic [33:0]       csr_pmp_addr_o [PMPNumRegions]
);
  import ibex_pkg::*;

  localparam logic [31:0] c_napot_ones = (PMPGranularity >= 2) ?
      ((32'd1 << ((PMPGranularity >= 2) ? PMPGranularity - 1 : 0)) - 32'd1) : 32'd0;
  localparam logic [31:0] c_off_zeros = (PMPGranularity >= 1) ?
      ((32'd1 << ((PMPGranularity >= 1) ? PMPGranularity : 0)) - 32'd1) : 32'd0;

  pmp_cfg_t    cfg_q  [16];
  pmp_cfg_t    cfg_d  [16];
  logic [31:0] addr_q [16];
  logic [31:0] addr_d [16];
  logic [7:0]  cfg_rd [16];
  logic [31:0] addr_rd [16];
  logic        next_tor_lock [16];
  logic        cfg_sel, addr_sel, wr_en;
  logic [31:0] new_val;

  function automatic pmp_cfg_t cfg_warl(input logic [7:0] b);
    pmp_cfg_t cfg;
    cfg.lock  = b[7];
    cfg.mode  = pmp_cfg_mode_e'(b[4:3]);
    if (cfg.mode == PMP_MODE_NA4 && PMPGranularity >= 1) cfg.mode = PMP_MODE_OFF;
    cfg.exec  = b[2];
    cfg.write = b[1] & b[0];
    cfg.read  = b[0];
    return cfg;
  endfunction

  assign cfg_sel   = (csr_addr_i[11:2] == 10'h0E8);
  assign addr_sel  = (csr_addr_i[11:4] == 8'h3B);
  assign csr_hit_o = cfg_sel | addr_sel;
  assign wr_en     = csr_access_i & csr_hit_o & (csr_op_i != 2'd0);

  // Software-visible views; stored pmpaddr bits are never altered by the mode.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      cfg_rd[i]  = {cfg_q[i].lock, 2'b00, cfg_q[i].mode, cfg_q[i].exec,
                    cfg_q[i].write, cfg_q[i].read};
      addr_rd[i] = addr_q[i];
      if (cfg_q[i].mode == PMP_MODE_NAPOT)
        addr_rd[i] = addr_q[i] | c_napot_ones;
      else if (cfg_q[i].mode == PMP_MODE_OFF || cfg_q[i].mode == PMP_MODE_TOR)
        addr_rd[i] = addr_q[i] & ~c_off_zeros;
    end
    for (int i = 0; i < 15; i++)
      next_tor_lock[i] = cfg_q[i+1].lock && (cfg_q[i+1].mode == PMP_MODE_TOR);
    next_tor_lock[15] = 1'b0;
  end

  always_comb begin
    csr_rdata_o = '0;
    if (cfg_sel) begin
      for (int k = 0; k < 4; k++)
        csr_rdata_o[8*k +: 8] = cfg_rd[{csr_addr_i[1:0], 2'(k)}];
    end else if (addr_sel) begin
      csr_rdata_o = addr_rd[csr_addr_i[3:0]];
    end
  end

  always_comb begin
    case (csr_op_i)
      2'd1:    new_val = csr_wdata_i;
      2'd2:    new_val = csr_rdata_o | csr_wdata_i;
      2'd3:    new_val = csr_rdata_o & ~csr_wdata_i;
      default: new_val = csr_rdata_o;
    endcase
  end

  // Unimplemented regions are held at zero so they read back 0.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      cfg_d[i]  = cfg_q[i];
      addr_d[i] = addr_q[i];
      if (i < PMPNumRegions) begin
        if (wr_en && cfg_sel && csr_addr_i[1:0] == 2'(i >> 2) && !cfg_q[i].lock)
          cfg_d[i] = cfg_warl(new_val[8*(i%4) +: 8]);
        if (wr_en && addr_sel && csr_addr_i[3:0] == 4'(i) &&
            !cfg_q[i].lock && !next_tor_lock[i])
          addr_d[i] = new_val;
      end else begin
        cfg_d[i]  = '0;
        addr_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_q  <= '{default: '0};
      addr_q <= '{default: '0};
    end else begin
      cfg_q  <= cfg_d;
      addr_q <= addr_d;
    end
  end

  for (genvar gi = 0; gi < PMPNumRegions; gi++) begin : g_out
    assign csr_pmp_cfg_o[gi]  = cfg_q[gi];
    assign csr_pmp_addr_o[gi] = {addr_q[gi], 2'b00};
  end

endmodule
`default_nettype wire
